// File: rtl/password_pkg.sv
`default_nettype none
// ============================================================================
// Module      : password_pkg
// Description : Shared definitions for the keypad password controller.
//               Holds the keypad codes, 7-segment character codes, the
//               four-character status words and the controller state type.
//               The NEWPW state exists only when PWLOCK_CHANGE_EN is defined.
// Revision    : 1.0 - first release
// ============================================================================
package password_pkg;

  // Keypad codes; 0..9 are digits.
  localparam logic [3:0] c_key_change = 4'hA;
  localparam logic [3:0] c_key_back   = 4'hB;
  localparam logic [3:0] c_key_clear  = 4'hC;
  localparam logic [3:0] c_key_enter  = 4'hE;

  // Display character codes understood by the 7-segment driver.
  localparam logic [3:0] c_ch_a    = 4'hA;
  localparam logic [3:0] c_ch_p    = 4'hB;
  localparam logic [3:0] c_ch_s    = 4'hC;
  localparam logic [3:0] c_ch_f    = 4'hD;
  localparam logic [3:0] c_ch_l    = 4'hE;
  localparam logic [3:0] c_ch_i    = 4'h1;
  localparam logic [3:0] c_ch_dash = 4'hF;

  // Status words shown on the four rightmost digits.
  localparam logic [15:0] c_word_pass = {c_ch_p, c_ch_a, c_ch_s, c_ch_s};
  localparam logic [15:0] c_word_fail = {c_ch_f, c_ch_a, c_ch_i, c_ch_l};
  localparam logic [15:0] c_word_lock = {c_ch_l, c_ch_l, c_ch_l, c_ch_l};

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ENTER   = 3'd1,
    ST_PASS    = 3'd2,
    ST_FAIL    = 3'd3,
    ST_LOCKOUT = 3'd4
`ifdef PWLOCK_CHANGE_EN
    ,
    ST_NEWPW   = 3'd5
`endif
  } state_e;

  function automatic logic is_digit(input logic [3:0] key);
    return (key <= 4'd9);
  endfunction

endpackage
`default_nettype wire

// File: rtl/hold_timer.sv
`default_nettype none
// ============================================================================
// Module      : hold_timer
// Description : Loadable down-counter with a registered one-cycle done flag.
//               After a load of N, done is high during the cycle that follows
//               the N-th clock edge after the load edge (N = 0: the cycle
//               right after the load). A client that leaves its state on
//               done therefore stays N+1 cycles.
// Ports       : clk        - clock
//               reset_n    - asynchronous active-low reset
//               load       - reload the counter with load_value
//               load_value - reload value
//               done       - registered expiry pulse
// Revision    : 1.0 - first release
// ============================================================================
module hold_timer #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  output logic             done
);

  logic [WIDTH-1:0] cnt_q;
  logic             done_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q  <= '0;
      done_q <= 1'b0;
    end else if (load) begin
      cnt_q  <= load_value;
      done_q <= (load_value == '0);
    end else begin
      if (cnt_q != '0) begin
        cnt_q <= cnt_q - 1'b1;
      end
      // Flag the edge on which the counter reaches zero.
      done_q <= (cnt_q == WIDTH'(1));
    end
  end

  assign done = done_q;

endmodule
`default_nettype wire

// File: rtl/password_lock_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : password_lock_ctrl
// Description : Keypad password controller. Collects BCD digits from the
//               keypad scanner, compares the code with the stored password,
//               shows PASS / FAIL / LOCK on the display and locks the keypad
//               out after MAX_TRIES consecutive failures.
//               Build macro PWLOCK_CHANGE_EN: enables in-field password
//               change (key A while in PASS) and the password register.
// Ports       : clk          - clock
//               reset_n      - asynchronous active-low reset
//               key_value    - key code (0..9, A change, B back, C clear,
//                              E enter)
//               key_valid    - one-cycle strobe qualifying key_value
//               display_data - one character code per digit, MSN leftmost
//               unlocked     - high while in PASS
//               locked_out   - high while in LOCKOUT
//               fail_count   - consecutive failed attempts (saturating)
// Revision    : 1.0 - first release
// ============================================================================
module password_lock_ctrl
  import password_pkg::*;
#(
  parameter int unsigned DIGITS      = 4,
  parameter logic [31:0] DEFAULT_PW  = 32'h0000_1234,
  parameter int unsigned HOLD_CYCLES = 100_000_000,
  parameter int unsigned LOCK_CYCLES = 500_000_000,
  parameter int unsigned MAX_TRIES   = 3
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [3:0]            key_value,
  input  logic                  key_valid,
  output logic [4*DIGITS-1:0]   display_data,
  output logic                  unlocked,
  output logic                  locked_out,
  output logic [3:0]            fail_count
);

  localparam int unsigned W       = 4 * DIGITS;
  localparam int unsigned CNT_W   = $clog2(DIGITS + 1);
  localparam int unsigned TMR_MAX = (HOLD_CYCLES > LOCK_CYCLES) ? HOLD_CYCLES : LOCK_CYCLES;
  localparam int unsigned TMR_W   = $clog2(TMR_MAX + 1);

  localparam logic [W-1:0]     c_all_dash = '1;
  localparam logic [CNT_W-1:0] c_last     = CNT_W'(DIGITS - 1);

  state_e           state_q, state_d;
  logic [W-1:0]     buf_q, buf_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       fail_q, fail_d;
  logic [W-1:0]     disp_q, disp_d;
  logic             unlocked_q, locked_q;

  logic [W-1:0]     w_pw;
  logic [W-1:0]     w_shift, w_back, w_cand;
  logic [3:0]       w_fail_inc;
  logic             w_digit, w_submit;
  logic             w_tmr_load, w_tmr_done;
  logic [TMR_W-1:0] w_tmr_value;

`ifdef PWLOCK_CHANGE_EN
  logic [W-1:0] pw_q, pw_d;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pw_q <= DEFAULT_PW[W-1:0];
    end else begin
      pw_q <= pw_d;
    end
  end

  assign w_pw = pw_q;
`else
  assign w_pw = DEFAULT_PW[W-1:0];
`endif

  // Display in upper digits is dash; status word in the low four digits.
  function automatic logic [W-1:0] word_disp(input logic [15:0] word);
    logic [W-1:0] v;
    v       = '1;
    v[15:0] = word;
    return v;
  endfunction

  assign w_shift    = {buf_q[W-5:0], key_value};
  assign w_back     = {c_ch_dash, buf_q[W-1:4]};
  assign w_digit    = is_digit(key_value);
  assign w_fail_inc = (fail_q == 4'hF) ? 4'hF : fail_q + 4'd1;

  always_comb begin
    state_d  = state_q;
    buf_d    = buf_q;
    cnt_d    = cnt_q;
    fail_d   = fail_q;
    w_submit = 1'b0;
    w_cand   = buf_q;
`ifdef PWLOCK_CHANGE_EN
    pw_d     = pw_q;
`endif

    case (state_q)
      ST_IDLE: begin
        buf_d = c_all_dash;
        cnt_d = '0;
        if (key_valid && w_digit) begin
          state_d = ST_ENTER;
          buf_d   = {c_all_dash[W-5:0], key_value};
          cnt_d   = CNT_W'(1);
        end
      end

      ST_ENTER: begin
        if (key_valid) begin
          if (w_digit) begin
            if (cnt_q == c_last) begin
              w_submit = 1'b1;
              w_cand   = w_shift;
            end else begin
              buf_d = w_shift;
              cnt_d = cnt_q + 1'b1;
            end
          end else begin
            case (key_value)
              c_key_enter: w_submit = 1'b1;
              c_key_clear: state_d  = ST_IDLE;
              c_key_back: begin
                if (cnt_q == CNT_W'(1)) begin
                  state_d = ST_IDLE;
                end else begin
                  buf_d = w_back;
                  cnt_d = cnt_q - 1'b1;
                end
              end
              default: ;
            endcase
          end
        end
      end

      ST_PASS: begin
        if (w_tmr_done) begin
          state_d = ST_IDLE;
`ifdef PWLOCK_CHANGE_EN
        end else if (key_valid && key_value == c_key_change) begin
          state_d = ST_NEWPW;
          buf_d   = c_all_dash;
          cnt_d   = '0;
`endif
        end
      end

      ST_FAIL: begin
        if (w_tmr_done) state_d = ST_IDLE;
      end

      ST_LOCKOUT: begin
        if (w_tmr_done) begin
          state_d = ST_IDLE;
          fail_d  = 4'd0;
        end
      end

`ifdef PWLOCK_CHANGE_EN
      ST_NEWPW: begin
        if (key_valid) begin
          if (w_digit) begin
            if (cnt_q == c_last) begin
              pw_d    = w_shift;
              state_d = ST_PASS;
            end else begin
              buf_d = w_shift;
              cnt_d = cnt_q + 1'b1;
            end
          end else begin
            case (key_value)
              c_key_enter,
              c_key_clear: state_d = ST_IDLE;
              c_key_back: begin
                if (cnt_q == CNT_W'(1)) begin
                  state_d = ST_IDLE;
                end else if (cnt_q != '0) begin
                  buf_d = w_back;
                  cnt_d = cnt_q - 1'b1;
                end
              end
              default: ;
            endcase
          end
        end
      end
`endif

      default: state_d = ST_IDLE;
    endcase

    // A short code still holds dash nibbles, so it can never match.
    if (w_submit) begin
      if (w_cand == w_pw) begin
        state_d = ST_PASS;
        fail_d  = 4'd0;
      end else begin
        fail_d  = w_fail_inc;
        state_d = (w_fail_inc >= 4'(MAX_TRIES)) ? ST_LOCKOUT : ST_FAIL;
      end
    end

    // Leaving the entry states always leaves an empty buffer behind.
    if (state_d != ST_ENTER
`ifdef PWLOCK_CHANGE_EN
        && state_d != ST_NEWPW
`endif
       ) begin
      buf_d = c_all_dash;
      cnt_d = '0;
    end
  end

  always_comb begin
    disp_d = c_all_dash;
    case (state_d)
      ST_ENTER:   disp_d = buf_d;
`ifdef PWLOCK_CHANGE_EN
      ST_NEWPW:   disp_d = buf_d;
`endif
      ST_PASS:    disp_d = word_disp(c_word_pass);
      ST_FAIL:    disp_d = word_disp(c_word_fail);
      ST_LOCKOUT: disp_d = word_disp(c_word_lock);
      default:    disp_d = c_all_dash;
    endcase
  end

  // Timer restarts on every state change; hold states load N-1 so that they
  // last exactly N cycles.
  assign w_tmr_load  = (state_d != state_q);
  assign w_tmr_value = (state_d == ST_PASS || state_d == ST_FAIL) ? TMR_W'(HOLD_CYCLES - 1) :
                       (state_d == ST_LOCKOUT)                    ? TMR_W'(LOCK_CYCLES - 1) :
                                                                    '0;

  hold_timer #(
    .WIDTH (TMR_W)
  ) u_hold_timer (
    .clk        (clk),
    .reset_n    (reset_n),
    .load       (w_tmr_load),
    .load_value (w_tmr_value),
    .done       (w_tmr_done)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      buf_q      <= c_all_dash;
      cnt_q      <= '0;
      fail_q     <= 4'd0;
      disp_q     <= c_all_dash;
      unlocked_q <= 1'b0;
      locked_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      buf_q      <= buf_d;
      cnt_q      <= cnt_d;
      fail_q     <= fail_d;
      disp_q     <= disp_d;
      unlocked_q <= (state_d == ST_PASS);
      locked_q   <= (state_d == ST_LOCKOUT);
    end
  end

  assign display_data = disp_q;
  assign unlocked     = unlocked_q;
  assign locked_out   = locked_q;
  assign fail_count   = fail_q;

endmodule
`default_nettype wire

// File: tb/tb_password_lock_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_password_lock_ctrl
// Description : Directed self-checking bench for password_lock_ctrl with
//               DIGITS=4, HOLD_CYCLES=20, LOCK_CYCLES=50, MAX_TRIES=3.
//               Password-change scenario runs when PWLOCK_CHANGE_EN is set.
// Revision    : 1.0 - first release
// ============================================================================
module tb_password_lock_ctrl;

  localparam logic [15:0] D_IDLE = 16'hFFFF;
  localparam logic [15:0] D_PASS = 16'hBACC;
  localparam logic [15:0] D_FAIL = 16'hDA1E;
  localparam logic [15:0] D_LOCK = 16'hEEEE;

  logic        clk = 1'b0;
  logic        reset_n = 1'b1;
  logic [3:0]  key_value = 4'd0;
  logic        key_valid = 1'b0;
  logic [15:0] display_data;
  logic        unlocked;
  logic        locked_out;
  logic [3:0]  fail_count;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  password_lock_ctrl #(
    .DIGITS      (4),
    .DEFAULT_PW  (32'h0000_1234),
    .HOLD_CYCLES (20),
    .LOCK_CYCLES (50),
    .MAX_TRIES   (3)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .key_value    (key_value),
    .key_valid    (key_valid),
    .display_data (display_data),
    .unlocked     (unlocked),
    .locked_out   (locked_out),
    .fail_count   (fail_count)
  );

  task automatic press(input logic [3:0] k);
    @(negedge clk);
    key_value = k;
    key_valid = 1'b1;
    @(negedge clk);
    key_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (display_data !== D_IDLE && n < 200) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (display_data !== D_IDLE) begin
      errors++;
      $display("FAIL wait_idle timeout display=%h required=%h", display_data, D_IDLE);
    end
  endtask

  // Cycles from 'start' until the display leaves 'word'.
  task automatic measure(input logic [15:0] word, input int start, output int dur);
    int n = 0;
    while (display_data === word && n < 1000) begin
      @(negedge clk);
      n++;
    end
    dur = cyc - start;
  endtask

  task automatic test_reset();
    #2 reset_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (display_data !== D_IDLE) begin errors++; $display("FAIL reset_display got=%h want=%h", display_data, D_IDLE); end
    checks++; if ({unlocked, locked_out, fail_count} !== 6'd0) begin errors++; $display("FAIL reset_flags got=%b%b%h want=000", unlocked, locked_out, fail_count); end
    reset_n = 1'b1;
    @(negedge clk);
    checks++; if (display_data !== D_IDLE) begin errors++; $display("FAIL post_reset_display got=%h want=%h", display_data, D_IDLE); end
  endtask

  task automatic test_pass();
    int st, dur;
    press(4'd1);
    checks++; if (display_data !== 16'hFFF1) begin errors++; $display("FAIL pass_d1 got=%h want=FFF1", display_data); end
    press(4'd2);
    checks++; if (display_data !== 16'hFF12) begin errors++; $display("FAIL pass_d2 got=%h want=FF12", display_data); end
    press(4'd3);
    checks++; if (display_data !== 16'hF123) begin errors++; $display("FAIL pass_d3 got=%h want=F123", display_data); end
    press(4'd4);
    st = cyc;
    checks++; if (display_data !== D_PASS) begin errors++; $display("FAIL pass_word got=%h want=%h", display_data, D_PASS); end
    checks++; if (unlocked !== 1'b1 || locked_out !== 1'b0) begin errors++; $display("FAIL pass_unlocked got=%b/%b want=1/0", unlocked, locked_out); end
    measure(D_PASS, st, dur);
    checks++; if (dur != 20) begin errors++; $display("FAIL pass_hold got=%0d want=20", dur); end
    checks++; if (display_data !== D_IDLE || unlocked !== 1'b0) begin errors++; $display("FAIL pass_end got=%h/%b want=%h/0", display_data, unlocked, D_IDLE); end
  endtask

  task automatic test_fail();
    int st, dur;
    press(4'd1); press(4'd2); press(4'hE);
    st = cyc;
    checks++; if (display_data !== D_FAIL) begin errors++; $display("FAIL fail_word got=%h want=%h", display_data, D_FAIL); end
    checks++; if (fail_count !== 4'd1 || unlocked !== 1'b0 || locked_out !== 1'b0) begin errors++; $display("FAIL fail_count got=%h/%b/%b want=1/0/0", fail_count, unlocked, locked_out); end
    measure(D_FAIL, st, dur);
    checks++; if (dur != 20) begin errors++; $display("FAIL fail_hold got=%0d want=20", dur); end
    checks++; if (display_data !== D_IDLE) begin errors++; $display("FAIL fail_end got=%h want=%h", display_data, D_IDLE); end
  endtask

  task automatic test_backspace();
    press(4'd1); press(4'd2);
    press(4'hB);
    checks++; if (display_data !== 16'hFFF1) begin errors++; $display("FAIL bs_first got=%h want=FFF1", display_data); end
    press(4'hB);
    checks++; if (display_data !== D_IDLE) begin errors++; $display("FAIL bs_to_idle got=%h want=%h", display_data, D_IDLE); end
    press(4'd5);
    press(4'hA);
    checks++; if (display_data !== 16'hFFF5) begin errors++; $display("FAIL enter_a_ignored got=%h want=FFF5", display_data); end
    press(4'hC);
    checks++; if (display_data !== D_IDLE) begin errors++; $display("FAIL clear got=%h want=%h", display_data, D_IDLE); end
    checks++; if (fail_count !== 4'd1) begin errors++; $display("FAIL clear_fail_count got=%h want=1", fail_count); end
  endtask

  task automatic test_lockout();
    int st, dur;
    repeat (4) press(4'd5);
    checks++; if (display_data !== D_FAIL || fail_count !== 4'd2) begin errors++; $display("FAIL lock_second got=%h/%h want=%h/2", display_data, fail_count, D_FAIL); end
    wait_idle();
    repeat (4) press(4'd9);
    st = cyc;
    checks++; if (display_data !== D_LOCK || locked_out !== 1'b1 || fail_count !== 4'd3) begin errors++; $display("FAIL lock_enter got=%h/%b/%h want=%h/1/3", display_data, locked_out, fail_count, D_LOCK); end
    press(4'd1); press(4'd2); press(4'd3); press(4'd4);
    checks++; if (display_data !== D_LOCK || locked_out !== 1'b1) begin errors++; $display("FAIL lock_ignore got=%h/%b want=%h/1", display_data, locked_out, D_LOCK); end
    measure(D_LOCK, st, dur);
    checks++; if (dur != 50) begin errors++; $display("FAIL lock_time got=%0d want=50", dur); end
    checks++; if (display_data !== D_IDLE || locked_out !== 1'b0 || fail_count !== 4'd0) begin errors++; $display("FAIL lock_end got=%h/%b/%h want=%h/0/0", display_data, locked_out, fail_count, D_IDLE); end
    press(4'd1); press(4'd2); press(4'd3); press(4'd4);
    checks++; if (display_data !== D_PASS || unlocked !== 1'b1) begin errors++; $display("FAIL lock_then_pass got=%h/%b want=%h/1", display_data, unlocked, D_PASS); end
    wait_idle();
  endtask

  task automatic test_back_to_back();
    int st, dur;
    @(negedge clk);
    key_valid = 1'b1;
    key_value = 4'd1; @(negedge clk);
    key_value = 4'd2; @(negedge clk);
    key_value = 4'd3; @(negedge clk);
    key_value = 4'd4; @(negedge clk);
    key_valid = 1'b0;
    st = cyc;
    checks++; if (display_data !== D_PASS || unlocked !== 1'b1) begin errors++; $display("FAIL b2b_pass got=%h/%b want=%h/1", display_data, unlocked, D_PASS); end
    measure(D_PASS, st, dur);
    checks++; if (dur != 20) begin errors++; $display("FAIL b2b_hold got=%0d want=20", dur); end
  endtask

`ifdef PWLOCK_CHANGE_EN
  task automatic test_change();
    press(4'd1); press(4'd2); press(4'd3); press(4'd4);
    press(4'hA);
    checks++; if (display_data !== D_IDLE || unlocked !== 1'b0) begin errors++; $display("FAIL newpw_enter got=%h/%b want=%h/0", display_data, unlocked, D_IDLE); end
    press(4'd9); press(4'd8); press(4'd7);
    checks++; if (display_data !== 16'hF987 || unlocked !== 1'b0) begin errors++; $display("FAIL newpw_digits got=%h/%b want=F987/0", display_data, unlocked); end
    press(4'd6);
    checks++; if (display_data !== D_PASS || unlocked !== 1'b1) begin errors++; $display("FAIL newpw_done got=%h/%b want=%h/1", display_data, unlocked, D_PASS); end
    wait_idle();
    press(4'd1); press(4'd2); press(4'd3); press(4'd4);
    checks++; if (display_data !== D_FAIL || fail_count !== 4'd1) begin errors++; $display("FAIL old_pw_rejected got=%h/%h want=%h/1", display_data, fail_count, D_FAIL); end
    wait_idle();
    press(4'd9); press(4'd8); press(4'd7); press(4'd6);
    checks++; if (display_data !== D_PASS || fail_count !== 4'd0) begin errors++; $display("FAIL new_pw_accepted got=%h/%h want=%h/0", display_data, fail_count, D_PASS); end
    wait_idle();
    @(negedge clk); reset_n = 1'b0;
    @(negedge clk); reset_n = 1'b1;
    press(4'd1); press(4'd2); press(4'd3); press(4'd4);
    checks++; if (display_data !== D_PASS) begin errors++; $display("FAIL reset_restores_pw got=%h want=%h", display_data, D_PASS); end
    wait_idle();
  endtask
`else
  task automatic test_change();
    int st, dur;
    press(4'd1); press(4'd2); press(4'd3); press(4'd4);
    st = cyc;
    press(4'hA);
    checks++; if (display_data !== D_PASS || unlocked !== 1'b1) begin errors++; $display("FAIL a_ignored got=%h/%b want=%h/1", display_data, unlocked, D_PASS); end
    measure(D_PASS, st, dur);
    checks++; if (dur != 20) begin errors++; $display("FAIL a_hold got=%0d want=20", dur); end
  endtask
`endif

  task automatic test_async_reset();
    for (int i = 0; i < 6; i++) begin
      repeat (4) press(4'd0);
      if (locked_out === 1'b1) break;
      wait_idle();
    end
    checks++; if (locked_out !== 1'b1 || display_data !== D_LOCK) begin errors++; $display("FAIL ar_locked got=%b/%h want=1/%h", locked_out, display_data, D_LOCK); end
    @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    checks++; if (display_data !== D_IDLE || {unlocked, locked_out, fail_count} !== 6'd0) begin errors++; $display("FAIL ar_async got=%h/%b/%b/%h want=%h/0/0/0", display_data, unlocked, locked_out, fail_count, D_IDLE); end
    @(negedge clk);
    reset_n = 1'b1;
    press(4'd1); press(4'd2); press(4'd3); press(4'd4);
    checks++; if (display_data !== D_PASS) begin errors++; $display("FAIL ar_then_pass got=%h want=%h", display_data, D_PASS); end
  endtask

  initial begin
    test_reset();
    test_pass();
    test_fail();
    test_backspace();
    test_lockout();
    test_back_to_back();
    test_change();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
